// File: rtl/crc_lanes.sv
// Multi-lane serial CRC engine: per-lane accumulate, counted MSB-first unload, zero-remainder flag.
// Optional CRC_SEED_EN: reset and clear load SEED into every lane instead of zero.
module crc_lanes #(
  parameter int unsigned      WIDTH = 7,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(7'h09),
  parameter int unsigned      LANES = 1,
  parameter logic [WIDTH-1:0] SEED  = '0
) (
  input  logic             iclk,
  input  logic             irst_n,
  input  logic             iclr,
  input  logic             ivalid,
  input  logic [LANES-1:0] idata,
  input  logic             iunload,
  output logic [LANES-1:0] ocrc,
  output logic             ocrc_valid,
  output logic             obusy,
  output logic             odone,
  output logic             ozero
);

  localparam int unsigned      CntW    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0]  CntLast = CntW'(WIDTH - 1);

`ifdef CRC_SEED_EN
  localparam logic [WIDTH-1:0] ClrVal = SEED;
`else
  // SEED is deliberately ignored in this build.
  localparam logic [WIDTH-1:0] ClrVal = SEED & '0;
`endif

  typedef enum logic {StIdle, StUnload} state_e;

  state_e                        state_q, state_d;
  logic [LANES-1:0][WIDTH-1:0]   crc_q, crc_d;
  logic [CntW-1:0]               cnt_q, cnt_d;
  logic                          done_q, done_d;

  function automatic logic [WIDTH-1:0] crc_step(input logic [WIDTH-1:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[WIDTH-1];
    return {crc[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
  endfunction

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (iclr) begin
      state_d = StIdle;
      crc_d   = {LANES{ClrVal}};
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          // Unload wins over a same-cycle data bit, which is dropped.
          if (iunload) begin
            state_d = StUnload;
            cnt_d   = CntLast;
          end else if (ivalid) begin
            for (int unsigned l = 0; l < LANES; l++) begin
              crc_d[l] = crc_step(crc_q[l], idata[l]);
            end
          end
        end
        StUnload: begin
          for (int unsigned l = 0; l < LANES; l++) begin
            crc_d[l] = {crc_q[l][WIDTH-2:0], 1'b0};
          end
          if (cnt_q == '0) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q <= StIdle;
      crc_q   <= {LANES{ClrVal}};
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      ocrc[l] = crc_q[l][WIDTH-1];
    end
  end

  assign ocrc_valid = (state_q == StUnload);
  assign obusy      = (state_q == StUnload);
  assign odone      = done_q;
  assign ozero      = (crc_q == '0);

endmodule
